fma_lza_pipe: RTL

//  Pipelined, flow-controlled leading-zero anticipator for the FMA datapath. Builds the

---
 rtl/fma_lza_pipe_if.sv | 40 ++++
 rtl/fma_lza_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fma_lza_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fma_lza_pipe_if
// Purpose  : Handshake and operand/result bundle for the FMA leading-zero
//            anticipator pipeline (input beat, result beat, tag sideband).
// Revision : 1.0 - initial release
// ============================================================================
interface fma_lza_pipe_if #(
   parameter int NF    = 52,
   parameter int TAG_W = 4
);
   localparam int WIDTH = 3*NF+6;
   localparam int CNT_W = $clog2(WIDTH+1);

   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [WIDTH-1:0]     A_i;
   logic [2*NF+1:0]      Pm_i;
   logic                 Cin_i;
   logic                 sub_i;
   logic [TAG_W-1:0]     tag_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [CNT_W-1:0]     SCnt_o;
   logic                 zero_o;
   logic [TAG_W-1:0]     tag_o;

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid_i, A_i, Pm_i, Cin_i, sub_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, SCnt_o, zero_o, tag_o
   );

   // Anticipator side
   modport slave (
      input  in_valid_i, A_i, Pm_i, Cin_i, sub_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, SCnt_o, zero_o, tag_o
   );
endinterface
`default_nettype wire

// File: rtl/fma_lza_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fma_lza_pipe
// Purpose  : Flow-controlled leading-zero anticipator. Builds the indicator
//            string F from the aligned addend and the product, then counts
//            its leading zeros to give the normalization shift count.
//            NUM_STAGES = 0 (combinational), 1 (output register) or
//            2 (F register, then count register).
// Revision : 1.0 - initial release
// ============================================================================
module fma_lza_pipe #(
   parameter int NF         = 52,
   parameter int WIDTH      = 3*NF+6,
   parameter int NUM_STAGES = 2,
   parameter int TAG_W      = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   fma_lza_pipe_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH+1);

   logic [WIDTH-1:0] w_B;
   logic [WIDTH-1:0] w_G;
   logic [WIDTH-1:0] w_K;
   logic [WIDTH-1:0] w_Pp1;
   logic [WIDTH-1:0] w_Gm1;
   logic [WIDTH-1:0] w_Km1;
   logic [WIDTH:0]   w_F;

   // Product sits two bits up, with zero headroom above it
   assign w_B   = {{(NF+2){1'b0}}, bus.Pm_i, 2'b00};
   assign w_G   = bus.A_i & w_B;
   assign w_K   = ~bus.A_i & ~w_B;
   // Propagate of the next-higher bit; the top position sees the sub flag
   assign w_Pp1 = {bus.sub_i, bus.A_i[WIDTH-1:1] ^ w_B[WIDTH-1:1]};
   // Generate/kill of the next-lower bit; carry-in acts as bit -1
   assign w_Gm1 = {w_G[WIDTH-2:0], bus.Cin_i};
   assign w_Km1 = {w_K[WIDTH-2:0], ~bus.Cin_i};

   // Extra top indicator catches a carry into the bit above the sum (add only)
   assign w_F[WIDTH]     = ~bus.sub_i & w_Pp1[WIDTH-2];
   assign w_F[WIDTH-1:0] = (w_Pp1  & ((w_G & ~w_Km1) | (w_K & ~w_Gm1)))
                         | (~w_Pp1 & ((w_K & ~w_Km1) | (w_G & ~w_Gm1)));

   // Leading-zero count from the MSB; returns {all_zero, count}, count 0 when all zero
   function automatic logic [CNT_W:0] lzc(input logic [WIDTH:0] f);
      logic [CNT_W-1:0] cnt;
      logic             found;
      cnt   = '0;
      found = 1'b0;
      for (int i = WIDTH; i >= 0; i--) begin
         if (!found) begin
            if (f[i]) found = 1'b1;
            else      cnt   = cnt + CNT_W'(1);
         end
      end
      if (!found) cnt = '0;
      return {~found, cnt};
   endfunction

   if (NUM_STAGES == 0) begin : g_comb
      logic [CNT_W:0] w_lz;
      assign w_lz            = lzc(w_F);
      assign bus.out_valid_o = bus.in_valid_i;
      assign bus.in_ready_o  = bus.out_ready_i;
      assign bus.SCnt_o      = w_lz[CNT_W-1:0];
      assign bus.zero_o      = w_lz[CNT_W];
      assign bus.tag_o       = bus.tag_i;
   end else if (NUM_STAGES == 1) begin : g_one
      logic             r_v;
      logic [CNT_W-1:0] r_cnt;
      logic             r_zero;
      logic [TAG_W-1:0] r_tag;
      logic             w_rdy;
      logic [CNT_W:0]   w_lz;

      assign w_lz  = lzc(w_F);
      assign w_rdy = ~r_v | bus.out_ready_i;

      // Output stage: valid tracks the handshake, data loads only on transfer
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_v    <= 1'b0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_tag  <= '0;
         end else begin
            if (flush_i)    r_v <= 1'b0;
            else if (w_rdy) r_v <= bus.in_valid_i;
            if (bus.in_valid_i && w_rdy) begin
               r_cnt  <= w_lz[CNT_W-1:0];
               r_zero <= w_lz[CNT_W];
               r_tag  <= bus.tag_i;
            end
         end
      end

      assign bus.in_ready_o  = w_rdy;
      assign bus.out_valid_o = r_v;
      assign bus.SCnt_o      = r_cnt;
      assign bus.zero_o      = r_zero;
      assign bus.tag_o       = r_tag;
   end else begin : g_two
      logic             r_v1;
      logic [WIDTH:0]   r_F;
      logic [TAG_W-1:0] r_tag1;
      logic             r_v2;
      logic [CNT_W-1:0] r_cnt;
      logic             r_zero;
      logic [TAG_W-1:0] r_tag2;
      logic             w_rdy1;
      logic             w_rdy2;
      logic [CNT_W:0]   w_lz;

      assign w_rdy2 = ~r_v2 | bus.out_ready_i;
      assign w_rdy1 = ~r_v1 | w_rdy2;
      assign w_lz   = lzc(r_F);

      // Stage 1: capture the indicator string and tag
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_v1   <= 1'b0;
            r_F    <= '0;
            r_tag1 <= '0;
         end else begin
            if (flush_i)     r_v1 <= 1'b0;
            else if (w_rdy1) r_v1 <= bus.in_valid_i;
            if (bus.in_valid_i && w_rdy1) begin
               r_F    <= w_F;
               r_tag1 <= bus.tag_i;
            end
         end
      end

      // Stage 2: count leading zeros of the held string
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_v2   <= 1'b0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_tag2 <= '0;
         end else begin
            if (flush_i)     r_v2 <= 1'b0;
            else if (w_rdy2) r_v2 <= r_v1;
            if (r_v1 && w_rdy2) begin
               r_cnt  <= w_lz[CNT_W-1:0];
               r_zero <= w_lz[CNT_W];
               r_tag2 <= r_tag1;
            end
         end
      end

      assign bus.in_ready_o  = w_rdy1;
      assign bus.out_valid_o = r_v2;
      assign bus.SCnt_o      = r_cnt;
      assign bus.zero_o      = r_zero;
      assign bus.tag_o       = r_tag2;
   end
endmodule
`default_nettype wire
